hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 30 +++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions for pipeline hazard control: FSM encodings,
// multiply latency default and the per-stage control bundle.
package hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_MUL_WAIT = 2'b10;
    localparam logic [1:0] ST_INIT     = 2'b11;

    localparam int unsigned MUL_LAT_DEFAULT = 4;

    typedef struct packed {
        logic f;
        logic d;
        logic e;
        logic m;
        logic w;
    } stage_ctrl_t;

    // A load in EX feeding either source of the ID instruction; x0 never hazards.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: generates per-stage bubble (hold) and flush
// (zero) controls for cache stalls, multi-cycle multiply, redirects and load-use.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] reg1_srcD,
    input  logic [4:0] reg2_srcD,
    input  logic [4:0] reg_dstE,
    input  logic       mem_readE,
    input  logic       br_takenE,
    input  logic       jalrE,
    input  logic       jalD,
    input  logic       mul_startE,
    input  logic       mem_reqM,
    input  logic       mem_ackM,
    output logic       bubbleF,
    output logic       bubbleD,
    output logic       bubbleE,
    output logic       bubbleM,
    output logic       bubbleW,
    output logic       flushF,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW
);

    localparam logic [3:0] MUL_CNT_LOAD = 4'(MUL_LAT - 2);

    logic [1:0]  state_q, state_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    stage_ctrl_t bubble, flush;
    logic        freeze;

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        bubble    = '0;
        flush     = '0;

        freeze = (((state_q == ST_RUN) || (state_q == ST_MUL_WAIT)) && mem_reqM && !mem_ackM)
              || ((state_q == ST_MEM_WAIT) && !mem_ackM);

        if (state_q == ST_INIT) begin
            flush   = '1;
            state_d = ST_RUN;
        end else if (freeze) begin
            // Freeze holds every stage; MUL_WAIT stays put with mul_cnt paused.
            bubble = '1;
            if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
            end
        end else begin
            case (state_q)
                ST_MEM_WAIT: state_d = ST_RUN;
                ST_MUL_WAIT: begin
                    // Held through the mul_cnt==0 cycle; released once back in RUN.
                    bubble.f = 1'b1;
                    bubble.d = 1'b1;
                    bubble.e = 1'b1;
                    flush.m  = 1'b1;
                    if (mul_cnt_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        mul_cnt_d = mul_cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (mul_startE) begin
                        state_d   = ST_MUL_WAIT;
                        mul_cnt_d = MUL_CNT_LOAD;
                    end
                    if (br_takenE || jalrE) begin
                        flush.d = 1'b1;
                        flush.e = 1'b1;
                    end else if (load_use_hit(mem_readE, reg_dstE, reg1_srcD, reg2_srcD)) begin
                        bubble.f = 1'b1;
                        bubble.d = 1'b1;
                        flush.e  = 1'b1;
                    end else if (jalD) begin
                        flush.d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign bubbleF = bubble.f;
    assign bubbleD = bubble.d;
    assign bubbleE = bubble.e;
    assign bubbleM = bubble.m;
    assign bubbleW = bubble.w;
    assign flushF  = flush.f;
    assign flushD  = flush.d;
    assign flushE  = flush.e;
    assign flushM  = flush.m;
    assign flushW  = flush.w;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a RUN-state vector table plus hand-built
// sequences for reset, memory freeze, multiply and reset during multiply.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] reg1_srcD, reg2_srcD, reg_dstE;
    logic       mem_readE, br_takenE, jalrE, jalD, mul_startE, mem_reqM, mem_ackM;
    logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic       flushF, flushD, flushE, flushM, flushW;

    int checks = 0;
    int errors = 0;

    // Expected words are {bubbleF..W, flushF..W}.
    localparam logic [9:0] E_ZERO = 10'b00000_00000;
    localparam logic [9:0] E_INIT = 10'b00000_11111;
    localparam logic [9:0] E_FRZ  = 10'b11111_00000;
    localparam logic [9:0] E_MUL  = 10'b11100_00010;
    localparam logic [9:0] E_RED  = 10'b00000_01100;
    localparam logic [9:0] E_LU   = 10'b11000_00100;
    localparam logic [9:0] E_JAL  = 10'b00000_01000;

    typedef struct {
        string      name;
        logic [4:0] r1, r2, rd;
        logic       mrd, br, jalr, jal, req, ack;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[14];

    hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg1_srcD(reg1_srcD), .reg2_srcD(reg2_srcD), .reg_dstE(reg_dstE),
        .mem_readE(mem_readE), .br_takenE(br_takenE), .jalrE(jalrE), .jalD(jalD),
        .mul_startE(mul_startE), .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
        .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE),
        .bubbleM(bubbleM), .bubbleW(bubbleW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .flushW(flushW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic mrd, input logic br,
                                input logic jalr, input logic jal, input logic req,
                                input logic ack, input logic [9:0] exp);
        vec_t v;
        v.name = n; v.r1 = r1; v.r2 = r2; v.rd = rd; v.mrd = mrd; v.br = br;
        v.jalr = jalr; v.jal = jal; v.req = req; v.ack = ack; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b_%b required %b_%b", name, act[9:5], act[4:0], exp[9:5], exp[4:0]);
        end
    endtask

    task automatic idle_inputs();
        reg1_srcD = '0; reg2_srcD = '0; reg_dstE = '0;
        mem_readE = 0; br_takenE = 0; jalrE = 0; jalD = 0;
        mul_startE = 0; mem_reqM = 0; mem_ackM = 0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO);
        tbl[1]  = mk("lu_rs2",    3, 5, 5, 1, 0, 0, 0, 0, 0, E_LU);
        tbl[2]  = mk("after_lu",  0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO);
        tbl[3]  = mk("lu_rs1",    7, 1, 7, 1, 0, 0, 0, 0, 0, E_LU);
        tbl[4]  = mk("lu_rd0",    3, 5, 0, 1, 0, 0, 0, 0, 0, E_ZERO);
        tbl[5]  = mk("lu_x0_src", 0, 0, 0, 1, 0, 0, 0, 0, 0, E_ZERO);
        tbl[6]  = mk("lu_nomatch",3, 4, 9, 1, 0, 0, 0, 0, 0, E_ZERO);
        tbl[7]  = mk("no_load",   3, 5, 5, 0, 0, 0, 0, 0, 0, E_ZERO);
        tbl[8]  = mk("br",        0, 0, 0, 0, 1, 0, 0, 0, 0, E_RED);
        tbl[9]  = mk("jalr_lu",   5, 2, 5, 1, 0, 1, 0, 0, 0, E_RED);
        tbl[10] = mk("br_lu",     3, 5, 5, 1, 1, 0, 0, 0, 0, E_RED);
        tbl[11] = mk("jal",       0, 0, 0, 0, 0, 0, 1, 0, 0, E_JAL);
        tbl[12] = mk("jal_lu",    3, 5, 5, 1, 0, 0, 1, 0, 0, E_LU);
        tbl[13] = mk("req_acked", 0, 0, 0, 0, 1, 0, 1, 1, 1, E_RED);

        idle_inputs();
        rst_n = 0;
        #12;
        chk("in_reset", E_INIT);

        // Reset release: one INIT cycle then RUN.
        next_cycle();
        rst_n = 1;
        #2 chk("init_cycle", E_INIT);
        next_cycle();
        chk("run_after_init", E_ZERO);

        foreach (tbl[i]) begin
            reg1_srcD = tbl[i].r1; reg2_srcD = tbl[i].r2; reg_dstE = tbl[i].rd;
            mem_readE = tbl[i].mrd; br_takenE = tbl[i].br; jalrE = tbl[i].jalr;
            jalD = tbl[i].jal; mem_reqM = tbl[i].req; mem_ackM = tbl[i].ack;
            #2 chk(tbl[i].name, tbl[i].exp);
            next_cycle();
        end
        idle_inputs();

        // Memory freeze: 3 stalled cycles, redirect ignored while waiting, then ack.
        mem_reqM = 1; mem_ackM = 0;
        #2 chk("mem_stall0", E_FRZ);
        next_cycle();
        br_takenE = 1;
        #2 chk("mem_stall1_br", E_FRZ);
        next_cycle();
        #2 chk("mem_stall2_br", E_FRZ);
        next_cycle();
        br_takenE = 0; mem_ackM = 1;
        #2 chk("mem_ack", E_ZERO);
        next_cycle();
        idle_inputs();
        #2 chk("mem_after", E_ZERO);
        next_cycle();

        // Multiply with no interference: held exactly 3 cycles after start.
        mul_startE = 1;
        #2 chk("mul_start", E_ZERO);
        next_cycle();
        mul_startE = 0;
        for (int unsigned k = 0; k < 3; k++) begin
            #2 chk($sformatf("mul_hold%0d", k), E_MUL);
            next_cycle();
        end
        #2 chk("mul_release", E_ZERO);
        next_cycle();

        // Multiply with a 2-cycle freeze mid-count: release 2 cycles later.
        mul_startE = 1;
        next_cycle();
        mul_startE = 0;
        #2 chk("mulf_hold0", E_MUL);
        next_cycle();
        mem_reqM = 1; mem_ackM = 0;
        #2 chk("mulf_frz0", E_FRZ);
        next_cycle();
        #2 chk("mulf_frz1", E_FRZ);
        next_cycle();
        mem_reqM = 0;
        #2 chk("mulf_hold1", E_MUL);
        next_cycle();
        #2 chk("mulf_hold2", E_MUL);
        next_cycle();
        #2 chk("mulf_release", E_ZERO);
        next_cycle();

        // Reset asserted while mul_cnt==1.
        mul_startE = 1;
        next_cycle();
        mul_startE = 0;
        next_cycle();
        #2 chk("mulr_hold_cnt1", E_MUL);
        rst_n = 0;
        #1 chk("mulr_async_init", E_INIT);
        next_cycle();
        #2 chk("mulr_in_reset", E_INIT);
        next_cycle();
        rst_n = 1;
        #2 chk("mulr_init_cycle", E_INIT);
        next_cycle();
        #2 chk("mulr_run0", E_ZERO);
        next_cycle();
        #2 chk("mulr_run1", E_ZERO);
        mul_startE = 1;
        next_cycle();
        mul_startE = 0;
        for (int unsigned k = 0; k < 3; k++) begin
            #2 chk($sformatf("mulr_rehold%0d", k), E_MUL);
            next_cycle();
        end
        #2 chk("mulr_rerelease", E_ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
